tt_logic_engine: RTL

//  Parametrised, reprogrammable truth-table logic gate: N_IN inputs, N_OUT outputs, table held in registers.

---
 rtl/tt_logic_engine.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tt_logic_engine.sv
// Reprogrammable truth-table gate with a valid/ready evaluation stream,
// atomic table reload and an exhaustive row sweep.
module tt_logic_engine #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 1,
  parameter logic [N_OUT*(2**N_IN)-1:0] DEFAULT_TT =
    (N_OUT*(2**N_IN))'(4'b1101)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  output logic [N_IN-1:0]  out_row,
  output logic             out_last,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [N_OUT-1:0] cfg_data,
  output logic             cfg_done,
  input  logic             sweep_start,
  output logic             busy
);

  localparam int ROWS = 1 << N_IN;
  localparam int W    = N_OUT * ROWS;
  localparam logic [N_IN-1:0] MAX = N_IN'(ROWS - 1);

  typedef enum logic [1:0] {
    EVAL  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]    tbl;
  logic [W-1:0]    shadow;
  logic [W-1:0]    shadow_nxt;
  logic [N_IN-1:0] row_cnt;
  logic            sweep_pend;

  logic free, acc, beat, commit;
  logic sw_req, sw_go, sw_issue, sw_end;

  function automatic logic [N_OUT-1:0] rd(
    input logic [W-1:0]    t,
    input logic [N_IN-1:0] r
  );
    return t[int'(r)*N_OUT +: N_OUT];
  endfunction

  assign free     = !out_valid || out_ready;
  assign in_ready = (state == EVAL) && free;
  assign acc      = in_valid && in_ready;
  assign beat     = (state == LOAD) && cfg_valid;
  assign commit   = beat && (row_cnt == MAX);
  assign sw_req   = sweep_start || sweep_pend;

  // A sweep waits while an eval result occupies or is entering the output.
  assign sw_go    = (state == EVAL) && sw_req && !cfg_start
                    && free && !acc;
  assign sw_issue = (state == SWEEP) && free
                    && !(out_valid && out_last);
  assign sw_end   = (state == SWEEP) && out_valid
                    && out_last && out_ready;
  assign busy     = (state != EVAL);

  always_comb begin
    shadow_nxt = shadow;
    if (beat) begin
      shadow_nxt[int'(row_cnt)*N_OUT +: N_OUT] = cfg_data;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EVAL: begin
        if (cfg_start)  state_nxt = LOAD;
        else if (sw_go) state_nxt = SWEEP;
      end
      LOAD: begin
        if (commit) state_nxt = EVAL;
      end
      SWEEP: begin
        if (sw_end) state_nxt = EVAL;
      end
      default: state_nxt = EVAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EVAL;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tbl        <= DEFAULT_TT;
      shadow     <= '0;
      row_cnt    <= '0;
      sweep_pend <= 1'b0;
      cfg_done   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_last   <= 1'b0;
    end else begin
      cfg_done <= commit;

      if (state == EVAL)
        sweep_pend <= sw_req && !cfg_start && !sw_go;
      else
        sweep_pend <= 1'b0;

      if (beat) shadow <= shadow_nxt;
      if (commit) tbl <= shadow_nxt;

      if (beat) begin
        row_cnt <= commit ? '0 : row_cnt + 1'b1;
      end else if (sw_issue && row_cnt != MAX) begin
        row_cnt <= row_cnt + 1'b1;
      end else if (sw_end) begin
        row_cnt <= '0;
      end

      if (acc) begin
        out_valid <= 1'b1;
        out_data  <= rd(tbl, in_data);
        out_row   <= in_data;
        out_last  <= 1'b0;
      end else if (sw_issue) begin
        out_valid <= 1'b1;
        out_data  <= rd(tbl, row_cnt);
        out_row   <= row_cnt;
        out_last  <= (row_cnt == MAX);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
